// File: rtl/pwl_mix_dsm.sv
// pwl_mix_dsm: collects one signed sample per channel per frame from the
// time-multiplexed ALU stream, sums them into a frame mix, flags frames whose
// channels arrive out of order, and drives a first-order delta-sigma
// modulator that turns the latest mix into a 1-bit audio bitstream.
module pwl_mix_dsm #(
   parameter int BITS    = 12,
   parameter int CH_BITS = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          in_valid,
   input  logic [CH_BITS-1:0]            in_ch,
   input  logic [BITS-1:0]               in_sample,
   input  logic [(1 << CH_BITS)-1:0]     ch_mask,
   input  logic                          err_clear,
   output logic [BITS+CH_BITS-1:0]       mix_out,
   output logic                          mix_valid,
   output logic                          frame_error,
   output logic                          dsm_out
);

   localparam int NUM_CHANNELS = 1 << CH_BITS;
   localparam int W            = BITS + CH_BITS;

   localparam logic [CH_BITS-1:0] FIRST_CH = CH_BITS'(0);
   localparam logic [CH_BITS-1:0] SECOND_CH = CH_BITS'(1);
   localparam logic [CH_BITS-1:0] LAST_CH  = CH_BITS'(NUM_CHANNELS - 1);

   // Frame collection state
   logic [CH_BITS-1:0] exp_ch_r;
   logic [W-1:0]       acc_r;

   // Modulator state
   logic [W-1:0]       dsm_acc_r;

   // Combinational helpers
   logic               accept_s;
   logic               in_order_s;
   logic               last_ch_s;
   logic               first_ch_s;
   logic [W-1:0]       term_s;
   logic [W-1:0]       sum_s;
   logic [W-1:0]       u_s;
   logic [W:0]         dsm_sum_s;

   // Decode the incoming sample: acceptance, ordering and its masked, sign-extended contribution
   always_comb begin
      accept_s   = en & in_valid;
      in_order_s = (in_ch == exp_ch_r);
      last_ch_s  = (in_ch == LAST_CH);
      first_ch_s = (in_ch == FIRST_CH);
      term_s     = '0;
      if (ch_mask[in_ch]) begin
         term_s = {{CH_BITS{in_sample[BITS-1]}}, in_sample};
      end else begin
         term_s = '0;
      end
      sum_s     = acc_r + term_s;
      // Offset-binary view of the mix: MSB inverted maps -2^(W-1)..2^(W-1)-1 onto 0..2^W-1
      u_s       = {~mix_out[W-1], mix_out[W-2:0]};
      dsm_sum_s = {1'b0, dsm_acc_r} + {1'b0, u_s};
   end

   // Frame accumulation: in-order samples build the sum, the last channel publishes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_ch_r  <= FIRST_CH;
         acc_r     <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
      end else begin
         // The pulse always drops on the following edge, even with en low
         mix_valid <= 1'b0;
         if (accept_s) begin
            if (in_order_s) begin
               if (last_ch_s) begin
                  mix_out   <= sum_s;
                  mix_valid <= 1'b1;
                  acc_r     <= '0;
                  exp_ch_r  <= FIRST_CH;
               end else begin
                  acc_r    <= sum_s;
                  exp_ch_r <= exp_ch_r + SECOND_CH;
               end
            end else begin
               // Partial frame is discarded; a channel-0 sample starts a fresh frame
               if (first_ch_s) begin
                  acc_r    <= term_s;
                  exp_ch_r <= SECOND_CH;
               end else begin
                  acc_r    <= '0;
                  exp_ch_r <= FIRST_CH;
               end
            end
         end else begin
            acc_r    <= acc_r;
            exp_ch_r <= exp_ch_r;
         end
      end
   end

   // Sticky out-of-order flag; a new error wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_error <= 1'b0;
      end else if (accept_s && !in_order_s) begin
         frame_error <= 1'b1;
      end else if (en && err_clear) begin
         frame_error <= 1'b0;
      end else begin
         frame_error <= frame_error;
      end
   end

   // First-order delta-sigma: the accumulator carry is the output bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dsm_acc_r <= '0;
         dsm_out   <= 1'b0;
      end else if (en) begin
         dsm_acc_r <= dsm_sum_s[W-1:0];
         dsm_out   <= dsm_sum_s[W];
      end else begin
         dsm_acc_r <= dsm_acc_r;
         dsm_out   <= dsm_out;
      end
   end

endmodule

// File: tb/tb_pwl_mix_dsm.sv
// Scoreboard bench for pwl_mix_dsm: directed frames push their hand-computed
// mix into a queue, and a monitor pops and compares on every mix_valid pulse.
module tb_pwl_mix_dsm;

   localparam int BITS    = 12;
   localparam int CH_BITS = 2;
   localparam int W       = BITS + CH_BITS;

   logic              clk;
   logic              rst;
   logic              en;
   logic              in_valid;
   logic [CH_BITS-1:0] in_ch;
   logic [BITS-1:0]   in_sample;
   logic [3:0]        ch_mask;
   logic              err_clear;
   logic [W-1:0]      mix_out;
   logic              mix_valid;
   logic              frame_error;
   logic              dsm_out;

   int n_vec;
   int n_err;
   int exp_q[$];
   logic prev_mv;

   pwl_mix_dsm #(.BITS(BITS), .CH_BITS(CH_BITS)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .in_valid(in_valid),
      .in_ch(in_ch),
      .in_sample(in_sample),
      .ch_mask(ch_mask),
      .err_clear(err_clear),
      .mix_out(mix_out),
      .mix_valid(mix_valid),
      .frame_error(frame_error),
      .dsm_out(dsm_out)
   );

   // Clock generation
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Present one sample for exactly one clock edge
   task automatic send(input int ch, input int s);
      in_valid  = 1'b1;
      in_ch     = CH_BITS'(ch);
      in_sample = BITS'(s);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
   endtask

   task automatic frame(input int s0, input int s1, input int s2, input int s3, input int mix);
      exp_q.push_back(mix);
      send(0, s0);
      send(1, s1);
      send(2, s2);
      send(3, s3);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare every mix pulse against the scoreboard head
   always @(negedge clk) begin
      if (!rst && mix_valid) begin
         if (prev_mv) begin
            n_vec++;
            n_err++;
            $display("FAIL mix_valid_width: high for 2 cycles, expected 1");
         end
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_mix_valid: mix_out %0d, expected no pulse", $signed(mix_out));
         end else begin
            chk("mix_out", int'($signed(mix_out)), exp_q.pop_front());
         end
      end
      prev_mv = mix_valid;
   end

   initial begin
      int ones;
      n_vec     = 0;
      n_err     = 0;
      prev_mv   = 1'b0;
      rst       = 1'b1;
      en        = 1'b1;
      in_valid  = 1'b0;
      in_ch     = '0;
      in_sample = '0;
      ch_mask   = 4'b1111;
      err_clear = 1'b0;
      #12;
      rst = 1'b0;

      // Reset state and idle modulator pattern (u = 8192 -> 0,1,0,1...)
      chk("rst_mix_out", int'(mix_out), 0);
      chk("rst_mix_valid", int'(mix_valid), 0);
      chk("rst_frame_error", int'(frame_error), 0);
      chk("rst_dsm_out", int'(dsm_out), 0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("idle_dsm_out", int'(dsm_out), i % 2);
      end

      // Basic frame then back-to-back frame
      frame(100, 200, -50, 1000, 1250);
      frame(1, 1, 1, 1, 4);
      idle(2);
      chk("hold_mix_out", int'($signed(mix_out)), 4);

      // Channel mask: only ch0 and ch2 contribute
      ch_mask = 4'b0101;
      frame(100, 200, -50, 1000, 50);
      idle(1);
      ch_mask = 4'b1111;

      // Positive full scale and its modulator density
      frame(2047, 2047, 2047, 2047, 8188);
      ones = 0;
      for (int i = 0; i < 16384; i++) begin
         @(posedge clk);
         #1;
         ones += int'(dsm_out);
      end
      chk("dsm_ones_fullscale", ones, 16380);

      // Negative full scale: modulator goes silent
      frame(-2048, -2048, -2048, -2048, -8192);
      idle(1);
      ones = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         ones += int'(dsm_out);
      end
      chk("dsm_ones_negscale", ones, 0);

      // Ordering errors
      send(0, 5);
      send(2, 7);
      chk("err_skip_ch", int'(frame_error), 1);
      frame(1, 2, 3, 4, 10);
      chk("err_sticky", int'(frame_error), 1);
      err_clear = 1'b1;
      send(3, 9);
      err_clear = 1'b0;
      chk("err_set_beats_clear", int'(frame_error), 1);
      err_clear = 1'b1;
      idle(1);
      err_clear = 1'b0;
      chk("err_clear", int'(frame_error), 0);
      send(0, 7);
      send(1, 8);
      frame(5, 5, 5, 5, 20);
      chk("err_restart_ch0", int'(frame_error), 1);

      // Reset mid-frame discards the partial sum
      send(0, 1);
      send(1, 2);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      chk("midrst_mix_out", int'(mix_out), 0);
      chk("midrst_frame_error", int'(frame_error), 0);
      send(2, 3);
      chk("midrst_err", int'(frame_error), 1);

      // Enable gap: fresh reset gives a known modulator phase (0,1,0,1...)
      rst = 1'b1;
      #2;
      rst = 1'b0;
      exp_q.push_back(100);
      send(0, 10);
      chk("gap_dsm_e1", int'(dsm_out), 0);
      send(1, 20);
      chk("gap_dsm_e2", int'(dsm_out), 1);
      en        = 1'b0;
      in_valid  = 1'b1;
      in_ch     = 2'd2;
      in_sample = 12'd30;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("gap_dsm_frozen", int'(dsm_out), 1);
         chk("gap_no_error", int'(frame_error), 0);
      end
      in_valid = 1'b0;
      en       = 1'b1;
      send(2, 30);
      chk("gap_dsm_resume", int'(dsm_out), 0);
      send(3, 40);
      idle(3);
      chk("gap_frame_error", int'(frame_error), 0);
      chk("gap_mix_out", int'($signed(mix_out)), 100);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pwl_mix_dsm.md
# pwl_mix_dsm

Output stage of the PWL synth, directly downstream of the multichannel ALU. It collects one signed sample per channel per frame from the ALU's time-multiplexed output stream and sums them into a frame mix. A first-order delta-sigma modulator turns the latest mix into a 1-bit audio pin. It also flags malformed frames, where a channel arrives out of order.

## Interface
Parameters:
- BITS, 12, per-channel sample width (signed two's complement)
- CH_BITS, 2, channel index width; NUM_CHANNELS = 1 << CH_BITS (4)
- Derived: W = BITS + CH_BITS (14), mix and modulator width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high; clears all state
- en  in  1  global enable; when low, all state holds and inputs are ignored
- in_valid  in  1  sample present this cycle
- in_ch  in  CH_BITS  channel index of in_sample
- in_sample  in  BITS  signed channel sample
- ch_mask  in  NUM_CHANNELS  bit i = 1 includes channel i in the mix; a masked-out channel contributes 0 but still advances the frame
- err_clear  in  1  clears frame_error
- mix_out  out  W  signed sum of the last complete frame
- mix_valid  out  1  one-cycle pulse when mix_out updates
- frame_error  out  1  sticky out-of-order flag
- dsm_out  out  1  delta-sigma bitstream

## Operation
- State:
  - exp_ch (CH_BITS): expected next channel
  - acc (W, signed): partial frame sum
  - dsm_acc (W, unsigned): modulator accumulator
- Accept condition: en && in_valid. Sample term s = ch_mask[in_ch] ? sign-extend(in_sample) : 0.
- In-order sample (in_ch == exp_ch):
  - in_ch < NUM_CHANNELS-1: acc <= acc + s; exp_ch <= exp_ch + 1.
  - in_ch == NUM_CHANNELS-1: mix_out <= acc + s; mix_valid <= 1; acc <= 0; exp_ch <= 0.
- Out-of-order sample (in_ch != exp_ch):
  - frame_error <= 1; the partial frame is discarded.
  - in_ch == 0: restart the frame with acc <= s, exp_ch <= 1.
  - otherwise: acc <= 0, exp_ch <= 0, and the sample is dropped.
  - No mix_valid pulse is produced.
- Width: W bits always hold NUM_CHANNELS full-scale samples (−2^(W−1) to 2^(W−1) − NUM_CHANNELS). No saturation logic exists.
- mix_valid is 0 in every cycle except the one after a completed frame.
- frame_error: set has priority over err_clear in the same cycle. err_clear alone clears it on the next edge.
- Modulator, every cycle with en = 1:
  - u = mix_out with its MSB inverted (offset binary).
  - {c, dsm_acc} <= dsm_acc + u; dsm_out <= c.
  - Long-run density of ones in dsm_out = u / 2^W.
- Modulator with en = 0: dsm_acc and dsm_out hold.
- A new mix_out takes effect in the modulator starting the cycle after it is registered.

## Timing
- Reset values: mix_out = 0, mix_valid = 0, frame_error = 0, dsm_out = 0. Internal state also resets: exp_ch = 0, acc = 0, dsm_acc = 0.
- Reset mid-frame discards the partial sum. The next accepted sample must be channel 0.
- Latency: the last-channel sample accepted on edge N produces mix_out/mix_valid visible after edge N.
- dsm_out first reflects the new mix from edge N+1.
- No backpressure: a sample is accepted every cycle in_valid && en. Back-to-back frames with zero gap are legal.
- en low mid-frame: exp_ch and acc are frozen, and the frame resumes when en returns.
- mix_valid deasserts on the next edge even if en drops.

## Test plan
- Idle after reset: rst pulse, en = 1, no input. Require mix_out = 0, frame_error = 0, and dsm_out = 0,1,0,1,… from the first edge (u = 8192).
- Basic frame: ch_mask = 1111, ch0..3 = 100, 200, −50, 1000 on consecutive cycles. Require mix_out = 1250 and a single-cycle mix_valid after ch3. A second back-to-back frame of 1,1,1,1 gives 4.
- Mask: ch_mask = 0101, frame 100, 200, −50, 1000. Require mix_out = 50. Masked channels still advance exp_ch.
- Full scale:
  - All 2047: mix_out = 8188; dsm_out has exactly 16380 ones in the 16384 cycles starting the edge after the mix update.
  - All −2048: mix_out = −8192; dsm_out stays 0.
- Ordering errors:
  - ch0, ch2: frame_error = 1, no mix_valid.
  - Then a clean 4-channel frame summing to 10: mix_out = 10, frame_error still 1.
  - err_clear together with a new bad sample: frame_error stays 1. err_clear alone clears it.
  - Mid-frame ch0 then 5,5,5,5 yields an error and mix_out = 20.
- Reset and enable:
  - ch0, ch1, then rst, then ch2: frame_error = 1.
  - en low for 3 cycles between ch1 and ch2 (in_valid held high): no state change; the frame completes with the correct sum and dsm_out frozen during the gap.
